// File: rtl/multicycle_hazard_unit.sv
// rtl/multicycle_hazard_unit.sv - IF-stage hold logic driven by a per-register latency countdown scoreboard
module multicycle_hazard_unit #(
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = 5,
    parameter int LAT_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [0:31]           instr_if,
    input  logic                  id_valid,
    input  logic                  flush_id,
    input  logic                  regWrite_id,
    input  logic [0:REG_BITS-1]   rd_id,
    input  logic [0:LAT_BITS-1]   lat_id,
    output logic                  stall,
    output logic                  stall_rs1,
    output logic                  stall_rs2,
    output logic                  busy
);

    // Fields of the instruction waiting in IF (opcode bit 0 is the MSB).
    logic [0:5]          opcode;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic                unused_instr;

    assign opcode       = instr_if[0:5];
    assign rs1          = REG_BITS'(instr_if[6:10]);
    assign rs2          = REG_BITS'(instr_if[11:15]);
    assign unused_instr = ^instr_if[16:31];

    // Source-use decode: which register fields the IF instruction really reads.
    logic jump_non_reg;
    logic r_type;
    logic is_store;
    logic rs1_used;
    logic rs2_used;

    always_comb begin
        jump_non_reg = (opcode[0:3] == 4'b0000) && opcode[4];
        r_type       = (opcode == 6'b000000);
        is_store     = (opcode[0:3] == 4'b1010) && (opcode[4:5] != 2'b10);
        // A read of r0 can never depend on a producer.
        rs1_used     = !jump_non_reg && (rs1 != '0);
        rs2_used     = (r_type || is_store) && (rs2 != '0);
    end

    // A real, unsquashed register-writing instruction is issuing from ID.
    logic                issue_id;
    logic [LAT_BITS-1:0] lat_v;
    logic [LAT_BITS-1:0] load_val;

    always_comb begin
        lat_v    = LAT_BITS'(lat_id);
        issue_id = id_valid && !flush_id && regWrite_id && (rd_id != '0);
        // Cycles still owed after this one; ALU results (latency 0) owe nothing.
        load_val = (lat_v == '0) ? '0 : (lat_v - LAT_BITS'(1));
    end

    // Scoreboard: cycles remaining until each register's pending result is usable.
    logic [LAT_BITS-1:0] cnt_q   [NUM_REGS];
    logic [LAT_BITS-1:0] cnt_d   [NUM_REGS];
    logic [LAT_BITS-1:0] cnt_dec [NUM_REGS];

    // Saturating decrement of every counter.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_dec[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_BITS'(1)) : '0;
        end
    end

    // Next counter value: a new producer may only lengthen the wait, never shorten it.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_dec[r];
            if (issue_id && (rd_id == REG_BITS'(r)) && (load_val > cnt_dec[r])) begin
                cnt_d[r] = load_val;
            end
        end
        cnt_d[0] = '0;
    end

    // Counter state; reset clears every pending producer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Hazard detection: the producer in ID now, or one already in the scoreboard.
    logic direct_rs1;
    logic direct_rs2;
    logic sb_rs1;
    logic sb_rs2;

    always_comb begin
        direct_rs1 = rs1_used && issue_id && (rd_id == rs1) && (lat_v != '0);
        direct_rs2 = rs2_used && issue_id && (rd_id == rs2) && (lat_v != '0);
        sb_rs1     = rs1_used && (cnt_q[rs1] != '0);
        sb_rs2     = rs2_used && (cnt_q[rs2] != '0);
        stall_rs1  = direct_rs1 || sb_rs1;
        stall_rs2  = direct_rs2 || sb_rs2;
        stall      = stall_rs1 || stall_rs2;
    end

    // Any producer still in flight.
    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy = busy || (cnt_q[r] != '0);
        end
    end

endmodule
